// File: rtl/alu_pkg.sv
// Shared ALU function codes, RV32I opcode/funct7 constants and the issue-buffer entry type.
// No logic beyond the funct3 lookup helper.
package alu_pkg;

    typedef enum logic [3:0] {
        FN_ZERO = 4'd0,
        FN_ADD  = 4'd1,
        FN_SUB  = 4'd2,
        FN_SLL  = 4'd3,
        FN_SLT  = 4'd4,
        FN_XOR  = 4'd5,
        FN_OR   = 4'd6,
        FN_AND  = 4'd7,
        FN_SRL  = 4'd8,
        FN_SRA  = 4'd9,
        FN_SLTU = 4'd10
    } alu_func_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_func_e   func;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] rs2_data;
        logic [4:0]  rd;
        logic        rd_we;
        logic        is_load;
        logic        is_store;
        logic        illegal;
    } issue_ent_t;

    // Base funct3 mapping shared by OP and OP-IMM; funct7 variants are applied by the caller.
    function automatic alu_func_e f3_func(input logic [2:0] f3);
        alu_func_e fn;
        case (f3)
            3'b000:  fn = FN_ADD;
            3'b001:  fn = FN_SLL;
            3'b010:  fn = FN_SLT;
            3'b011:  fn = FN_SLTU;
            3'b100:  fn = FN_XOR;
            3'b101:  fn = FN_SRL;
            3'b110:  fn = FN_OR;
            default: fn = FN_AND;
        endcase
        return fn;
    endfunction

endpackage

// File: rtl/alu_decode.sv
// RV32I to ALU function/operand translation for the issue stage.
// Purely combinational, no handshake.
// Illegal encodings produce a zeroed ZERO-function entry with illegal set.
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output alu_func_e   func,
    output logic [31:0] op1,
    output logic [31:0] op2,
    output logic [4:0]  rd,
    output logic        rd_we,
    output logic        is_load,
    output logic        is_store,
    output logic        illegal
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic        legal;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign rd     = instr[11:7];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u  = {instr[31:12], 12'b0};

    always_comb begin
        func     = FN_ZERO;
        op1      = '0;
        op2      = '0;
        rd_we    = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        legal    = 1'b1;
        case (opcode)
            OPC_OP: begin
                op1   = rs1;
                op2   = rs2;
                rd_we = 1'b1;
                func  = f3_func(f3);
                if (f7 == F7_ALT) begin
                    if (f3 == 3'b000)      func  = FN_SUB;
                    else if (f3 == 3'b101) func  = FN_SRA;
                    else                   legal = 1'b0;
                end else if (f7 != F7_BASE) begin
                    legal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                op1   = rs1;
                op2   = imm_i;
                rd_we = 1'b1;
                func  = f3_func(f3);
                // Upper bits are only a funct7 field for shifts; elsewhere they are immediate.
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    op2 = {27'b0, instr[24:20]};
                    if (f7 == F7_ALT && f3 == 3'b101) func  = FN_SRA;
                    else if (f7 != F7_BASE)           legal = 1'b0;
                end
            end
            OPC_LUI: begin
                func  = FN_ADD;
                op2   = imm_u;
                rd_we = 1'b1;
            end
            OPC_AUIPC: begin
                func  = FN_ADD;
                op1   = pc;
                op2   = imm_u;
                rd_we = 1'b1;
            end
            OPC_LOAD: begin
                func    = FN_ADD;
                op1     = rs1;
                op2     = imm_i;
                rd_we   = 1'b1;
                is_load = 1'b1;
            end
            OPC_STORE: begin
                func     = FN_ADD;
                op1      = rs1;
                op2      = imm_s;
                is_store = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            func     = FN_ZERO;
            op1      = '0;
            op2      = '0;
            rd_we    = 1'b0;
            is_load  = 1'b0;
            is_store = 1'b0;
        end
        if (rd == 5'd0) rd_we = 1'b0;
    end

    assign illegal = ~legal;

endmodule

// File: rtl/alu_issue.sv
// Execute-stage issue: decodes an RV32I instruction into ALU func/operands into a 2-entry skid buffer.
// Latency 1 cycle from accept to out_*.
// in_ready is registered (not full), so downstream stalls never form a combinational ready path.
module alu_issue
    import alu_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [DataWidth-1:0] in_pc,
    input  logic [DataWidth-1:0] in_rs1_data,
    input  logic [DataWidth-1:0] in_rs2_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           out_func,
    output logic [DataWidth-1:0] out_op1,
    output logic [DataWidth-1:0] out_op2,
    output logic [DataWidth-1:0] out_rs2_data,
    output logic [4:0]           out_rd,
    output logic                 out_rd_we,
    output logic                 out_is_load,
    output logic                 out_is_store,
    output logic                 out_illegal
);

    alu_func_e   dec_func;
    logic [31:0] dec_op1;
    logic [31:0] dec_op2;
    logic [4:0]  dec_rd;
    logic        dec_rd_we;
    logic        dec_is_load;
    logic        dec_is_store;
    logic        dec_illegal;
    issue_ent_t  dec_ent;

    alu_decode u_decode (
        .instr    (in_instr),
        .pc       (in_pc),
        .rs1      (in_rs1_data),
        .rs2      (in_rs2_data),
        .func     (dec_func),
        .op1      (dec_op1),
        .op2      (dec_op2),
        .rd       (dec_rd),
        .rd_we    (dec_rd_we),
        .is_load  (dec_is_load),
        .is_store (dec_is_store),
        .illegal  (dec_illegal)
    );

    assign dec_ent = '{func: dec_func, op1: dec_op1, op2: dec_op2, rs2_data: in_rs2_data,
                       rd: dec_rd, rd_we: dec_rd_we, is_load: dec_is_load,
                       is_store: dec_is_store, illegal: dec_illegal};

    logic [1:0] count;
    logic [1:0] count_nxt;
    issue_ent_t head_q;
    issue_ent_t tail_q;
    logic       push;
    logic       pop;

    assign push = in_valid & in_ready & ~flush;
    assign pop  = (count != 2'd0) & out_ready;

    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = 2'd0;
        end else if (push && !pop) begin
            count_nxt = count + 2'd1;
        end else if (pop && !push) begin
            count_nxt = count - 2'd1;
        end
    end

    // Head always drives out_*; the tail only fills when the head is held by a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= 2'd0;
            in_ready <= 1'b0;
            head_q   <= '0;
            tail_q   <= '0;
        end else begin
            count    <= count_nxt;
            in_ready <= (count_nxt != 2'd2);
            if (!flush) begin
                if (count == 2'd2) begin
                    if (pop) head_q <= tail_q;
                end else if (push && (count == 2'd0 || pop)) begin
                    head_q <= dec_ent;
                end else if (push) begin
                    tail_q <= dec_ent;
                end
            end
        end
    end

    assign out_valid    = (count != 2'd0);
    assign out_func     = head_q.func;
    assign out_op1      = head_q.op1;
    assign out_op2      = head_q.op2;
    assign out_rs2_data = head_q.rs2_data;
    assign out_rd       = head_q.rd;
    assign out_rd_we    = head_q.rd_we;
    assign out_is_load  = head_q.is_load;
    assign out_is_store = head_q.is_store;
    assign out_illegal  = head_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed plus randomized checks of alu_issue against a queue-based reference model.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_func;
    logic [31:0] out_op1;
    logic [31:0] out_op2;
    logic [31:0] out_rs2_data;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic        out_is_load;
    logic        out_is_store;
    logic        out_illegal;

    int tests = 0;
    int fails = 0;

    logic [108:0] mq[$];
    logic         mrdy;

    always #5 clk = ~clk;

    alu_issue #(.DataWidth(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_func(out_func),
        .out_op1(out_op1), .out_op2(out_op2), .out_rs2_data(out_rs2_data),
        .out_rd(out_rd), .out_rd_we(out_rd_we), .out_is_load(out_is_load),
        .out_is_store(out_is_store), .out_illegal(out_illegal)
    );

    // Entry layout: {func, op1, op2, rs2_data, rd, rd_we, is_load, is_store, illegal}
    function automatic logic [108:0] ref_dec(input logic [31:0] ins, input logic [31:0] pc,
                                             input logic [31:0] a_rs1, input logic [31:0] a_rs2);
        int          f3map[8] = '{1, 3, 4, 10, 5, 8, 6, 7};
        int          f3 = int'(ins[14:12]);
        int          f7 = int'(ins[31:25]);
        logic [4:0]  rd = ins[11:7];
        logic [31:0] iimm = 32'($signed(ins) >>> 20);
        logic [31:0] simm = (iimm & 32'hFFFF_FFE0) | 32'(rd);
        logic [31:0] uimm = ins & 32'hFFFF_F000;
        int          fn = 0;
        logic [31:0] a = 0;
        logic [31:0] b = 0;
        bit          we = 0, ld = 0, st = 0, ok = 1;
        case (ins[6:0])
            7'h33: begin
                a = a_rs1; b = a_rs2; we = 1; fn = f3map[f3];
                if (f7 == 32 && f3 == 0)      fn = 2;
                else if (f7 == 32 && f3 == 5) fn = 9;
                else if (f7 != 0)             ok = 0;
            end
            7'h13: begin
                a = a_rs1; we = 1; fn = f3map[f3];
                if (f3 == 1 || f3 == 5) begin
                    b = 32'(ins[24:20]);
                    if (f3 == 5 && f7 == 32) fn = 9;
                    else if (f7 != 0)        ok = 0;
                end else begin
                    b = iimm;
                end
            end
            7'h37: begin fn = 1; b = uimm; we = 1; end
            7'h17: begin fn = 1; a = pc; b = uimm; we = 1; end
            7'h03: begin fn = 1; a = a_rs1; b = iimm; we = 1; ld = 1; end
            7'h23: begin fn = 1; a = a_rs1; b = simm; st = 1; end
            default: ok = 0;
        endcase
        if (!ok) begin fn = 0; a = 0; b = 0; we = 0; ld = 0; st = 0; end
        if (rd == 0) we = 0;
        return {4'(fn), a, b, a_rs2, rd, we, ld, st, !ok};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        logic [6:0]  opc;
        int          k = $urandom_range(0, 9);
        int          sel = $urandom_range(0, 3);
        case (k)
            0, 1:    opc = 7'h33;
            2, 3:    opc = 7'h13;
            4:       opc = 7'h37;
            5:       opc = 7'h17;
            6:       opc = 7'h03;
            7:       opc = 7'h23;
            8:       opc = 7'h73;
            default: opc = 7'($urandom);
        endcase
        r[6:0] = opc;
        if (opc == 7'h33 || opc == 7'h13) begin
            if (sel < 2)       r[31:25] = 7'h00;
            else if (sel == 2) r[31:25] = 7'h20;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of inputs, checks outputs against the model, then advances both.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input logic ordy, input logic fl);
        logic [108:0] obs;
        bit           push, pop;
        in_valid = v; in_instr = ins; in_pc = pc; in_rs1_data = r1; in_rs2_data = r2;
        out_ready = ordy; flush = fl;
        #1;
        obs = {out_func, out_op1, out_op2, out_rs2_data, out_rd, out_rd_we,
               out_is_load, out_is_store, out_illegal};
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(mrdy));
        if (mq.size() > 0) begin
            tests++;
            assert (obs === mq[0]) else begin
                fails++;
                $error("FAIL head_entry: got %h expected %h", obs, mq[0]);
            end
        end
        push = v && mrdy && !fl;
        pop  = (mq.size() > 0) && ordy;
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(ref_dec(ins, pc, r1, r2));
        end
        mrdy = (mq.size() < 2);
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, ordy, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;
        mrdy = 1'b0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_func", 32'(out_func), 32'd0);
        chk("rst_op1", out_op1, 32'd0);
        chk("rst_op2", out_op2, 32'd0);
        chk("rst_rs2", out_rs2_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1);
        chk("ready_after_rst", 32'(in_ready), 32'd1);

        // add x3,x1,x2
        step(1'b1, 32'h002081B3, 32'h100, 32'd5, 32'd7, 1'b1, 1'b0);
        chk("add_func", 32'(out_func), 32'd1);
        chk("add_op1", out_op1, 32'd5);
        chk("add_op2", out_op2, 32'd7);
        chk("add_rd", 32'(out_rd), 32'd3);
        chk("add_rd_we", 32'(out_rd_we), 32'd1);
        // srai x5,x6,4 then the same with funct7=0100001
        step(1'b1, 32'h40435293, 32'h104, 32'h80000000, 32'd0, 1'b1, 1'b0);
        chk("srai_func", 32'(out_func), 32'd9);
        chk("srai_op2", out_op2, 32'd4);
        chk("srai_rd_we", 32'(out_rd_we), 32'd1);
        step(1'b1, 32'h42435293, 32'h108, 32'h80000000, 32'd0, 1'b1, 1'b0);
        chk("bad_srai_ill", 32'(out_illegal), 32'd1);
        chk("bad_srai_func", 32'(out_func), 32'd0);
        // lui x0,0x12345 and sw x2,-4(x1)
        step(1'b1, 32'h12345037, 32'h10C, 32'd1, 32'd2, 1'b1, 1'b0);
        chk("lui_op2", out_op2, 32'h12345000);
        chk("lui_rd_we", 32'(out_rd_we), 32'd0);
        step(1'b1, 32'hFE20AE23, 32'h110, 32'h1000, 32'hCAFE, 1'b1, 1'b0);
        chk("sw_func", 32'(out_func), 32'd1);
        chk("sw_op2", out_op2, 32'hFFFFFFFC);
        chk("sw_store", 32'(out_is_store), 32'd1);
        chk("sw_rd_we", 32'(out_rd_we), 32'd0);
        idle(1'b1);

        // Stall: three back-to-back valids, then drain in order
        step(1'b1, 32'h00100093, 32'h200, 32'd1, 32'd0, 1'b0, 1'b0);
        step(1'b1, 32'h00200113, 32'h204, 32'd2, 32'd0, 1'b0, 1'b0);
        step(1'b1, 32'h00300193, 32'h208, 32'd3, 32'd0, 1'b0, 1'b0);
        chk("stall_op2_head", out_op2, 32'd1);
        repeat (3) idle(1'b1);

        // Flush with full buffer and an offered input
        step(1'b1, 32'h00A00213, 32'h300, 32'd0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 32'h00B00293, 32'h304, 32'd0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 32'h00C00313, 32'h308, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd1);
        repeat (2) idle(1'b1);

        // Async reset mid-stall with count=2
        step(1'b1, 32'h00D00393, 32'h400, 32'd0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 32'h00E00413, 32'h404, 32'd0, 32'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd0);
        chk("arst_op2", out_op2, 32'd0);
        mq.delete();
        mrdy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b0);
        step(1'b1, 32'h7FF00493, 32'h500, 32'd9, 32'd0, 1'b0, 1'b0);
        idle(1'b0);
        chk("arst_alone_op2", out_op2, 32'h7FF);
        idle(1'b1);
        idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom, $urandom, $urandom,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
        end
        repeat (3) idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Execute-stage issue block directly upstream of the `ALU`. Accepts one decoded-stage RV32I instruction per cycle with its register operands and PC. Translates it into the ALU function code plus the two 32-bit operands, and holds the result in a 2-entry skid buffer so the ALU/writeback side can stall without a combinational ready path. Also carries destination-register and memory-kind sideband, and supports a synchronous pipeline flush.

## Interface
- `DataWidth`, 32: operand/PC width; only 32 is supported.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `flush` input 1: synchronous kill of all buffered entries; takes priority over accept.
- `in_valid` input 1: upstream offers an instruction.
- `in_ready` output 1: block can accept; registered, equals "buffer not full".
- `in_instr` input 32: raw instruction word.
- `in_pc` input 32: PC of the instruction.
- `in_rs1_data`, `in_rs2_data` input 32 each: register operands, already forwarded.
- `out_valid` output 1: issued entry present.
- `out_ready` input 1: downstream consumes the entry.
- `out_func` output 4: ALU function code.
- `out_op1`, `out_op2` output 32: ALU operands.
- `out_rs2_data` output 32: store data, passed through.
- `out_rd` output 5: destination register.
- `out_rd_we` output 1: register write enable.
- `out_is_load`, `out_is_store` output 1 each: ALU result is a memory address.
- `out_illegal` output 1: instruction not decodable by this block.

## Operation
Function codes: ZERO=0, ADD=1, SUB=2, SLL=3, SLT=4, XOR=5, OR=6, AND=7, SRL=8, SRA=9, SLTU=10.

- **OP (0110011):** op1=rs1, op2=rs2.
  - funct3 map: 000 ADD, or SUB if funct7=0100000; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA if funct7=0100000; 110 OR; 111 AND.
  - funct7 must be 0000000. The only other legal value is 0100000, and only with funct3 000/101; anything else is illegal.
- **OP-IMM (0010011):** same funct3 map, with no SUB. op1=rs1, op2=sign-extended I-immediate.
  - Shifts (001/101): op2={27'b0, instr[24:20]}.
  - instr[31:25] must be 0000000. 0100000 is allowed only for funct3 101, which selects SRA. Otherwise illegal.
- **LUI (0110111):** ADD, op1=0, op2={instr[31:12],12'b0}.
- **AUIPC (0010111):** ADD, op1=pc, op2=U-immediate.
- **LOAD (0000011):** ADD, op1=rs1, op2=I-immediate, is_load=1.
- **STORE (0100011):** ADD, op1=rs1, op2=S-immediate, is_store=1, rd_we=0.
- **Any other opcode, or an illegal funct:**
  - func=ZERO, op1=op2=0, rd_we=0, is_load=is_store=0, illegal=1.
  - The entry is still issued so downstream can trap.
- rd_we=1 for OP, OP-IMM, LUI, AUIPC and LOAD, forced to 0 when rd=0.
- All arithmetic is 32-bit; immediates are sign-extended from instr[31].

## Timing
- Accept occurs when in_valid & in_ready & !flush. Decode is combinational on the input and captured into the buffer; the entry is visible on out_* the next cycle (latency 1).
- The buffer is a 2-entry FIFO: head drives out_*, the tail catches an accept made while the head is stalled. Order is strictly preserved.
- in_ready = (count<2), registered. A simultaneous accept and consume at count=2 is impossible, because in_ready=0.
- Pop occurs when out_valid & out_ready. A push and a pop in the same cycle keep count unchanged.
- out_valid=1 iff count>0; out_* are stable while out_valid & !out_ready.
- Flush: next cycle count=0, out_valid=0, in_ready=1. An input offered in the flush cycle is dropped.
- Reset (async assert, any time, including mid-stall):
  - count=0, out_valid=0, in_ready=0 during reset, 1 on the first cycle after release.
  - All out_* data fields are 0 and out_func=ZERO.

## Structure
- Shared package `alu_pkg`: the ALU function-code constants (shared with `ALU`), RV32I opcode constants, and funct7 constants 0000000/0100000.
- Sub-module `alu_decode` is purely combinational: instr, pc, rs1, rs2 in; func, op1, op2, rd, rd_we, is_load, is_store, illegal out.
- The top level holds the 2-entry buffer, count, handshake and flush logic.

## Test plan
- `add x3,x1,x2` (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle: func=1, op1=5, op2=7, rd=3, rd_we=1.
- `srai x5,x6,4` (0x40435293), rs1=0x80000000 -> func=9, op2=4, rd_we=1; with funct7=0100001 instead -> illegal=1, func=0.
- `lui x0,0x12345` -> op2=0x12345000, rd_we=0. `sw x2,-4(x1)` -> func=1, op2=0xFFFFFFFC, is_store=1, rd_we=0.
- out_ready=0, three back-to-back valids -> first two accepted, in_ready=0 on the third; raise out_ready -> drained in order, no loss.
- Flush asserted with count=2 and in_valid=1 -> next cycle out_valid=0, in_ready=1, no later output of those three instructions.
- rst_n pulsed low mid-stall with count=2 -> out_valid drops asynchronously; after release the first accepted instruction emerges alone.
